// File: rtl/bang_pkg.sv
// Shared constants and helpers for the voice/sample-memory blocks.
package bang_pkg;

  localparam int unsigned NVOICES_DEF = 4;
  localparam int unsigned AW_DEF      = 16;
  localparam int unsigned DW_DEF      = 8;

  // Bits needed to encode a voice id; never less than 1.
  function automatic int unsigned id_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sample_mem_arb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick
  import bang_pkg::*;
#(
  parameter int unsigned N   = NVOICES_DEF,
  parameter int unsigned IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] id,
  output logic           any
);

  logic [IDW-1:0] idx;

  // Scan last+1 .. last+N modulo N; the first hit wins.
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IDW'((32'(last) + k) % N);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        id       = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_mem_arb.sv
// Round-robin arbiter sharing one sample-memory read port between voices.
module sample_mem_arb
  import bang_pkg::*;
#(
  parameter int unsigned NVOICES = NVOICES_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NVOICES-1:0]    req,
  input  logic [NVOICES*AW-1:0] addr_in,
  output logic [NVOICES-1:0]    gnt,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_rd,
  input  logic [DW-1:0]         mem_data,
  output logic [NVOICES*DW-1:0] dout,
  output logic [NVOICES-1:0]    dvalid
);

  localparam int unsigned IDW = id_width(NVOICES);

  logic [IDW-1:0]     last;
  logic [IDW-1:0]     pick_id;
  logic [NVOICES-1:0] pick_gnt;
  logic               pick_any;
  logic               take;
  logic [AW-1:0]      sel_addr;
  logic [IDW-1:0]     issue_id;
  logic               pipe_v  [RD_LAT];
  logic [IDW-1:0]     pipe_id [RD_LAT];

  rr_pick #(
    .N   (NVOICES),
    .IDW (IDW)
  ) u_pick (
    .req  (req),
    .last (last),
    .gnt  (pick_gnt),
    .id   (pick_id),
    .any  (pick_any)
  );

  // Reset suppresses the grant so nothing is accepted in a reset cycle.
  always_comb begin
    take     = pick_any & ~rst;
    gnt      = take ? pick_gnt : '0;
    sel_addr = addr_in[32'(pick_id)*AW +: AW];
  end

  // Issue stage: drive the memory port and remember the granted voice.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      issue_id <= '0;
      last     <= IDW'(NVOICES - 1);
    end else begin
      mem_rd   <= take;
      issue_id <= pick_id;
      if (take) begin
        mem_addr <= sel_addr;
        last     <= pick_id;
      end
    end
  end

  // The issue register is the head of the tracker; these RD_LAT stages line
  // the voice id up with the cycle in which mem_data is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_v[i]  <= 1'b0;
        pipe_id[i] <= '0;
      end
    end else begin
      pipe_v[0]  <= mem_rd;
      pipe_id[0] <= issue_id;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  // Capture returning data into the owning voice's register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout   <= '0;
      dvalid <= '0;
    end else begin
      dvalid <= '0;
      if (pipe_v[RD_LAT-1]) begin
        dout[32'(pipe_id[RD_LAT-1])*DW +: DW] <= mem_data;
        dvalid[pipe_id[RD_LAT-1]]             <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_mem_arb.sv
// Bench: two arbiters (RD_LAT=1 and RD_LAT=3) share stimulus; a transaction
// model predicts grants, issue and return for both every cycle.
module tb_sample_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] addr_in = '0;

  logic [3:0]  gnt1, gnt3, dv1, dv3;
  logic [15:0] maddr1, maddr3;
  logic        rd1, rd3;
  logic [31:0] dout1, dout3;
  logic [7:0]  md1;
  logic [7:0]  md3_a, md3_b, md3_c;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sample_mem_arb #(.NVOICES(4), .AW(16), .DW(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .gnt(gnt1),
    .mem_addr(maddr1), .mem_rd(rd1), .mem_data(md1), .dout(dout1), .dvalid(dv1)
  );

  sample_mem_arb #(.NVOICES(4), .AW(16), .DW(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .gnt(gnt3),
    .mem_addr(maddr3), .mem_rd(rd3), .mem_data(md3_c), .dout(dout3), .dvalid(dv3)
  );

  // Memories return the low address byte, RD_LAT cycles after the address.
  always @(posedge clk) begin
    md1   <= maddr1[7:0];
    md3_a <= maddr3[7:0];
    md3_b <= md3_a;
    md3_c <= md3_b;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction model ----------------
  logic        m_on    [2];
  logic        m_rd    [2];
  logic [15:0] m_maddr [2];
  int          m_last  [2];
  logic [31:0] m_dout  [2];
  logic        s_v     [2][16];
  int          s_id    [2][16];
  logic [7:0]  s_d     [2][16];

  initial for (int k = 0; k < 2; k++) m_on[k] = 1'b0;

  always @(negedge clk) begin
    int lat, v, slot;
    logic [3:0]  eg, edv, agnt, adv;
    logic        ard;
    logic [15:0] aaddr, a;
    logic [31:0] adout;
    for (int k = 0; k < 2; k++) begin
      lat   = (k == 0) ? 1 : 3;
      agnt  = (k == 0) ? gnt1 : gnt3;
      adv   = (k == 0) ? dv1 : dv3;
      ard   = (k == 0) ? rd1 : rd3;
      aaddr = (k == 0) ? maddr1 : maddr3;
      adout = (k == 0) ? dout1 : dout3;
      slot  = cyc % 16;
      if (m_on[k]) begin
        chk($sformatf("L%0d mem_rd", lat), 64'(ard), 64'(m_rd[k]));
        chk($sformatf("L%0d mem_addr", lat), 64'(aaddr), 64'(m_maddr[k]));
        edv = '0;
        if (s_v[k][slot]) begin
          m_dout[k][s_id[k][slot]*8 +: 8] = s_d[k][slot];
          edv[s_id[k][slot]] = 1'b1;
          s_v[k][slot] = 1'b0;
        end
        chk($sformatf("L%0d dvalid", lat), 64'(adv), 64'(edv));
        chk($sformatf("L%0d dout", lat), 64'(adout), 64'(m_dout[k]));
      end
      eg = '0;
      v  = -1;
      if (!rst) begin
        for (int j = 1; j <= 4; j++)
          if (v < 0 && req[(m_last[k] + j) % 4]) v = (m_last[k] + j) % 4;
        if (v >= 0) eg[v] = 1'b1;
      end
      if (m_on[k]) chk($sformatf("L%0d gnt", lat), 64'(agnt), 64'(eg));
      if (rst) begin
        m_on[k]    = 1'b1;
        m_rd[k]    = 1'b0;
        m_maddr[k] = '0;
        m_last[k]  = 3;
        m_dout[k]  = '0;
        for (int t = 0; t < 16; t++) s_v[k][t] = 1'b0;
      end else if (v >= 0) begin
        a          = addr_in[v*16 +: 16];
        m_rd[k]    = 1'b1;
        m_maddr[k] = a;
        m_last[k]  = v;
        slot       = (cyc + 2 + lat) % 16;
        s_v[k][slot]  = 1'b1;
        s_id[k][slot] = v;
        s_d[k][slot]  = a[7:0];
      end else begin
        m_rd[k] = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    logic [7:0] b;

    // Single voice
    do_reset();
    req = 4'b0100;
    addr_in[32 +: 16] = 16'h0010;
    @(negedge clk) chk("single gnt", 64'(gnt1), 64'h4);
    tick();
    req = '0;
    @(negedge clk);
    chk("single mem_rd", 64'(rd1), 64'h1);
    chk("single mem_addr", 64'(maddr1), 64'h0010);
    tick();
    tick();
    @(negedge clk);
    b = dout1[23:16];
    chk("single dvalid", 64'(dv1), 64'h4);
    chk("single dout", 64'(b), 64'h10);
    repeat (5) tick();

    // All requesting
    do_reset();
    req = 4'b1111;
    addr_in = {16'h0330, 16'h0220, 16'h0110, 16'h0000};
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      g = gnt1;
      if (n < 8) chk($sformatf("all gnt %0d", n), 64'(g), 64'(4'b0001 << (n % 4)));
      tick();
      for (int v = 0; v < 4; v++)
        if (g[v]) addr_in[v*16 +: 16] = addr_in[v*16 +: 16] + 16'd1;
    end
    req = '0;
    repeat (6) tick();

    // Rotation from last=3
    do_reset();
    req = 4'b1010;
    @(negedge clk) chk("rot gnt 0", 64'(gnt1), 64'h2);
    tick();
    @(negedge clk) chk("rot gnt 1", 64'(gnt1), 64'h8);
    tick();
    @(negedge clk) chk("rot gnt 2", 64'(gnt1), 64'h2);
    tick();
    req = '0;
    repeat (6) tick();

    // Lone streamer
    do_reset();
    req = 4'b0001;
    addr_in[15:0] = 16'h0100;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      g = gnt1;
      chk($sformatf("stream gnt %0d", n), 64'(g), 64'h1);
      if (n >= 3) begin
        b = dout1[7:0];
        chk($sformatf("stream dout %0d", n), 64'(b), 64'(n - 3));
      end
      tick();
      if (g[0]) addr_in[15:0] = addr_in[15:0] + 16'd1;
    end
    req = '0;
    repeat (8) tick();

    // Reset mid-flight, with simultaneous requests
    do_reset();
    req = 4'b0010;
    addr_in[16 +: 16] = 16'h0055;
    @(negedge clk) chk("midrst gnt", 64'(gnt1), 64'h2);
    tick();
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    chk("midrst gnt in rst", 64'(gnt1), 64'h0);
    chk("midrst mem_rd", 64'(rd1), 64'h1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst mem_rd cleared", 64'(rd1), 64'h0);
    chk("midrst mem_addr cleared", 64'(maddr1), 64'h0);
    chk("midrst gnt after", 64'(gnt1), 64'h1);
    tick();
    req = '0;
    @(negedge clk) chk("midrst no dvalid", 64'(dv1), 64'h0);
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_mem_arb.md
# sample_mem_arb

Round-robin arbiter that shares the single sample-memory read port between several playback voices. Each voice posts a read request with its current sample address. The arbiter grants at most one request per clock and issues that read to memory. It then routes the returned byte back to the requesting voice after a fixed memory latency. It sits between the voice bank and the sample ROM/SRAM, and is the only block that drives the memory address bus.

## Interface
- `NVOICES`, 4: number of voices sharing the port; range 2..8.
- `AW`, 16: sample address width; matches the voice `addr` width.
- `DW`, 8: sample data width.
- `RD_LAT`, 1: memory read latency in clocks, from `mem_rd` to `mem_data` valid; range 1..3.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NVOICES  per-voice read request, level.
- `addr_in`  in  NVOICES*AW  per-voice address; voice i occupies bits [i*AW +: AW].
- `gnt`  out  NVOICES  one-hot, one-cycle pulse; the request is accepted this cycle.
- `mem_addr`  out  AW  address to sample memory.
- `mem_rd`  out  1  read strobe, one cycle per accepted request.
- `mem_data`  in  DW  memory read data, valid RD_LAT cycles after `mem_rd`.
- `dout`  out  NVOICES*DW  per-voice returned-sample register; voice i occupies bits [i*DW +: DW].
- `dvalid`  out  NVOICES  one-cycle pulse; `dout` for voice i has been updated.

## Operation
- **Request handshake**
  - A voice raises `req[i]` and holds `addr_in` for that voice stable until it sees `gnt[i]`.
  - After `gnt[i]`, the voice may drop `req[i]`, or keep it high with a new address to request the next sample.
- **Arbitration**
  - Combinational round-robin pick over `req`.
  - Search starts at `last+1` modulo NVOICES, where `last` is a register holding the most recently granted voice id.
  - Exactly one `gnt` bit is high when any `req` bit is high; `gnt` is all zeros otherwise.
- **Registered issue**
  - On a grant, `mem_addr` takes the granted voice's address and `mem_rd`=1 on the next edge.
  - `last` updates to the granted id on the same edge.
- **Return tracking**
  - A shift register of depth RD_LAT carries {valid, voice id} alongside each read.
  - When the tail entry is valid, `mem_data` is latched into that voice's `dout` slice and `dvalid` for that voice pulses.
- **Fairness**
  - A continuously requesting voice waits at most NVOICES-1 grants.
  - A lone requester is granted every cycle.
- **Idle**
  - `mem_rd`=0.
  - `mem_addr` holds its last value.
  - `last` is unchanged.
- **Reset**
  - `gnt`=0, `mem_rd`=0, `mem_addr`=0, `dout`=0, `dvalid`=0.
  - `last`=NVOICES-1, so voice 0 has first priority.
  - The tracking pipe is cleared.
- **Reset mid-operation**
  - In-flight reads are discarded: no `dvalid` is produced for them.
  - Data returned after reset is ignored.

## Timing
- Grant-to-read latency:
  - `gnt[i]` is a combinational pulse in cycle T.
  - `mem_rd`=1 and `mem_addr` = that voice's address in cycle T+1.
- Read-to-return latency:
  - `mem_data` is valid in cycle T+1+RD_LAT.
  - `dout` for voice i and `dvalid[i]` are registered in cycle T+2+RD_LAT.
  - End-to-end latency from grant to `dvalid` is RD_LAT+2 cycles.
- Throughput is one read per cycle sustained, with back-to-back grants to different voices.
- Reads are fully pipelined: up to RD_LAT+1 reads are in flight.
- `dvalid` is one-hot or zero in every cycle, because returns arrive in issue order.
- `dout` for a voice holds its value until that voice's next return.
- Simultaneous `rst` and `req`: reset wins; no grant is issued that cycle.

## Structure
- **Shared package `bang_pkg`** holds:
  - default constants `NVOICES_DEF`, `AW_DEF`, `DW_DEF`;
  - a clog2-style function for voice-id width, with a minimum of 1.
- **Sub-module `rr_pick`** is the combinational round-robin priority picker.
  - Inputs: `req`, `last`.
  - Outputs: one-hot `gnt`, encoded `id`, `any`.
- **Top level** holds the issue registers, the tracking shift register and the per-voice `dout` registers.

## Test plan
Unless stated otherwise, scenarios use NVOICES=4, RD_LAT=1, with a memory model returning `mem_data` = `mem_addr[7:0]`.
- **Single voice:** after reset, voice 2 holds `req`, `addr_in` = 0x0010.
  - Required: `gnt[2]` in cycle 0; `mem_rd`, `mem_addr`=0x0010 in cycle 1; `dout` for voice 2 = 0x10 with `dvalid[2]` in cycle 3.
- **All requesting:** all four `req` high continuously from reset.
  - Required grant sequence: 0,1,2,3,0,1,…
  - `mem_rd` high every cycle.
  - Each voice sees `dvalid` once per 4 cycles.
- **Rotation:** `req`=1010 after voice 3 was last granted.
  - Required: voice 1 granted, then voice 3, then voice 1.
- **Lone streamer:** voice 0 holds `req`, incrementing `addr_in` after each `gnt`, from 0x0100 to 0x0107.
  - Required: 8 consecutive grants.
  - `dout` for voice 0 returns 0x00..0x07 on consecutive cycles.
- **Reset mid-flight:** `rst` asserted the cycle after `mem_rd`.
  - Required: no `dvalid`; all outputs 0; the next grant goes to voice 0.
- **Latency sweep:** repeat the all-requesting scenario with RD_LAT=3.
  - Required: `dvalid` arrives exactly 5 cycles after each grant.
  - Data matches the issued address order.
